// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: an age-ordered scoreboard of in-flight register
// writes drives per-operand forwarding selects and stall/flush/freeze controls.
module pipe_hazard_unit #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 3,
  parameter  int LOAD_STAGE = 1,
  localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iss_valid_i,
  input  logic                      iss_wr_i,
  input  logic [REG_AW-1:0]         iss_rd_i,
  input  logic                      iss_load_i,
  input  logic [NUM_SRC*REG_AW-1:0] iss_rs_i,
  input  logic [NUM_SRC-1:0]        iss_rs_used_i,
  input  logic                      br_taken_i,
  input  logic                      mem_wait_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_iss_o,
  output logic                      bubble_ex_o,
  output logic                      flush_iss_o,
  output logic                      freeze_o,
  output logic [31:0]               stall_cnt_o
);

  logic              sb_valid_q [FWD_DEPTH];
  logic              sb_wr_q    [FWD_DEPTH];
  logic [REG_AW-1:0] sb_rd_q    [FWD_DEPTH];
  logic              sb_load_q  [FWD_DEPTH];
  logic              sb_valid_d [FWD_DEPTH];
  logic              sb_wr_d    [FWD_DEPTH];
  logic [REG_AW-1:0] sb_rd_d    [FWD_DEPTH];
  logic              sb_load_d  [FWD_DEPTH];

  logic [NUM_SRC-1:0] op_hazard;
  logic               load_use;
  logic [31:0]        stall_cnt_q;
  logic [31:0]        stall_cnt_d;

  always_comb begin : match_logic
    fwd_sel_o = '0;
    op_hazard = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      // Scan oldest to youngest so the youngest matching entry is the one left standing.
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (sb_valid_q[k] && sb_wr_q[k] && iss_rs_used_i[n] &&
            (iss_rs_i[n*REG_AW +: REG_AW] != '0) &&
            (sb_rd_q[k] == iss_rs_i[n*REG_AW +: REG_AW])) begin
          if (!sb_load_q[k] || (k >= LOAD_STAGE)) begin
            fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(k + 1);
            op_hazard[n] = 1'b0;
          end else begin
            fwd_sel_o[n*SEL_W +: SEL_W] = '0;
            op_hazard[n] = 1'b1;
          end
        end
      end
    end
    load_use = iss_valid_i && (|op_hazard);
  end

  always_comb begin : control_logic
    freeze_o    = 1'b0;
    stall_iss_o = 1'b0;
    bubble_ex_o = 1'b0;
    flush_iss_o = 1'b0;
    // Controls are forced low while reset is asserted, independent of the inputs.
    if (reset) begin
      if (mem_wait_i) begin
        freeze_o = 1'b1;
      end else if (br_taken_i) begin
        flush_iss_o = 1'b1;
        bubble_ex_o = 1'b1;
      end else if (load_use) begin
        stall_iss_o = 1'b1;
        bubble_ex_o = 1'b1;
      end
    end
  end

  always_comb begin : advance_logic
    for (int k = 0; k < FWD_DEPTH; k++) begin
      sb_valid_d[k] = sb_valid_q[k];
      sb_wr_d[k]    = sb_wr_q[k];
      sb_rd_d[k]    = sb_rd_q[k];
      sb_load_d[k]  = sb_load_q[k];
    end
    stall_cnt_d = stall_cnt_q;
    if (!freeze_o) begin
      sb_valid_d[0] = iss_valid_i && !bubble_ex_o;
      sb_wr_d[0]    = iss_wr_i;
      sb_rd_d[0]    = iss_rd_i;
      sb_load_d[0]  = iss_load_i;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sb_valid_d[k] = sb_valid_q[k-1];
        sb_wr_d[k]    = sb_wr_q[k-1];
        sb_rd_d[k]    = sb_rd_q[k-1];
        sb_load_d[k]  = sb_load_q[k-1];
      end
    end
    if ((stall_iss_o || freeze_o) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        sb_valid_q[k] <= 1'b0;
        sb_wr_q[k]    <= 1'b0;
        sb_rd_q[k]    <= '0;
        sb_load_q[k]  <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        sb_valid_q[k] <= sb_valid_d[k];
        sb_wr_q[k]    <= sb_wr_d[k];
        sb_rd_q[k]    <= sb_rd_d[k];
        sb_load_q[k]  <= sb_load_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a default build and a
// NUM_SRC=3 / FWD_DEPTH=4 / LOAD_STAGE=2 build driven in sequence.
module tb_pipe_hazard_unit;

  logic clk;
  logic a_rst_n;
  logic b_rst_n;

  logic        a_valid, a_wr, a_load, a_br, a_mw;
  logic [4:0]  a_rd;
  logic [9:0]  a_rs;
  logic [1:0]  a_used;
  logic [3:0]  a_fwd;
  logic        a_stall, a_bubble, a_flush, a_freeze;
  logic [31:0] a_cnt;

  logic        p_valid, p_wr, p_load, p_br, p_mw;
  logic [4:0]  p_rd;
  logic [14:0] p_rs;
  logic [2:0]  p_used;
  logic [8:0]  p_fwd;
  logic        p_stall, p_bubble, p_flush, p_freeze;
  logic [31:0] p_cnt;

  int vectors;
  int miscompares;

  pipe_hazard_unit u_dut_a (
    .clk           (clk),
    .reset         (a_rst_n),
    .iss_valid_i   (a_valid),
    .iss_wr_i      (a_wr),
    .iss_rd_i      (a_rd),
    .iss_load_i    (a_load),
    .iss_rs_i      (a_rs),
    .iss_rs_used_i (a_used),
    .br_taken_i    (a_br),
    .mem_wait_i    (a_mw),
    .fwd_sel_o     (a_fwd),
    .stall_iss_o   (a_stall),
    .bubble_ex_o   (a_bubble),
    .flush_iss_o   (a_flush),
    .freeze_o      (a_freeze),
    .stall_cnt_o   (a_cnt)
  );

  pipe_hazard_unit #(
    .REG_AW     (5),
    .NUM_SRC    (3),
    .FWD_DEPTH  (4),
    .LOAD_STAGE (2)
  ) u_dut_p (
    .clk           (clk),
    .reset         (b_rst_n),
    .iss_valid_i   (p_valid),
    .iss_wr_i      (p_wr),
    .iss_rd_i      (p_rd),
    .iss_load_i    (p_load),
    .iss_rs_i      (p_rs),
    .iss_rs_used_i (p_used),
    .br_taken_i    (p_br),
    .mem_wait_i    (p_mw),
    .fwd_sel_o     (p_fwd),
    .stall_iss_o   (p_stall),
    .bubble_ex_o   (p_bubble),
    .flush_iss_o   (p_flush),
    .freeze_o      (p_freeze),
    .stall_cnt_o   (p_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic [4:0] rd,
                               input logic load, input logic [4:0] rs0,
                               input logic [4:0] rs1, input logic [1:0] used,
                               input logic br, input logic mw);
    a_valid = valid;
    a_wr    = wr;
    a_rd    = rd;
    a_load  = load;
    a_rs    = {rs1, rs0};
    a_used  = used;
    a_br    = br;
    a_mw    = mw;
  endtask

  task automatic applyStimulusP(input logic valid, input logic wr, input logic [4:0] rd,
                                input logic load, input logic [4:0] rs0,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] used, input logic br, input logic mw);
    p_valid = valid;
    p_wr    = wr;
    p_rd    = rd;
    p_load  = load;
    p_rs    = {rs2, rs1, rs0};
    p_used  = used;
    p_br    = br;
    p_mw    = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    a_rst_n     = 1'b0;
    b_rst_n     = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1);
    applyStimulusP(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1);
    #2;
    checkOutput("reset_fwd", 32'(a_fwd), 32'd0);
    checkOutput("reset_freeze_gated", 32'(a_freeze), 32'd0);
    checkOutput("reset_flush_gated", 32'(a_flush), 32'd0);
    checkOutput("reset_cnt", a_cnt, 32'd0);
    checkOutput("reset_p_freeze_gated", 32'(p_freeze), 32'd0);
    checkOutput("reset_p_fwd", 32'(p_fwd), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    applyStimulusP(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // ALU chain: add r3,r1,r2 ; add r4,r3,r3 ; add r5,r3,r4
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("alu_first_fwd", 32'(a_fwd), 32'h0);
    checkOutput("alu_first_stall", 32'(a_stall), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 5'd3, 5'd3, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("alu_b2b_fwd", 32'(a_fwd), 32'b0101);
    checkOutput("alu_b2b_stall", 32'(a_stall), 32'd0);
    checkOutput("alu_b2b_bubble", 32'(a_bubble), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd3, 5'd4, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("alu_third_fwd", 32'(a_fwd), 32'b0110);
    tick();

    // Load-use: lw r5 ; add r6,r5,r0
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lw_issue_stall", 32'(a_stall), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd6, 1'b0, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("loaduse_stall", 32'(a_stall), 32'd1);
    checkOutput("loaduse_bubble", 32'(a_bubble), 32'd1);
    checkOutput("loaduse_cnt_before", a_cnt, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("loaduse_after_stall", 32'(a_stall), 32'd0);
    checkOutput("loaduse_after_bubble", 32'(a_bubble), 32'd0);
    checkOutput("loaduse_after_fwd", 32'(a_fwd), 32'b0010);
    checkOutput("loaduse_cnt", a_cnt, 32'd1);
    tick();

    // Register 0: lw r0 ; reader of r0
    applyStimulus(1'b1, 1'b1, 5'd0, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("r0_fwd", 32'(a_fwd), 32'd0);
    checkOutput("r0_stall", 32'(a_stall), 32'd0);
    tick();

    // Branch taken coinciding with a load-use hazard
    applyStimulus(1'b1, 1'b1, 5'd8, 1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd8, 5'd0, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("br_flush", 32'(a_flush), 32'd1);
    checkOutput("br_bubble", 32'(a_bubble), 32'd1);
    checkOutput("br_stall", 32'(a_stall), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("br_after_fwd", 32'(a_fwd), 32'b0010);
    checkOutput("br_after_cnt", a_cnt, 32'd1);
    tick();

    // Asynchronous reset pulse during a pending load-use stall
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd10, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("prereset_stall", 32'(a_stall), 32'd1);
    #1 a_rst_n = 1'b0;
    #1;
    checkOutput("areset_stall", 32'(a_stall), 32'd0);
    checkOutput("areset_bubble", 32'(a_bubble), 32'd0);
    checkOutput("areset_cnt", a_cnt, 32'd0);
    #1 a_rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("postreset_stall", 32'(a_stall), 32'd0);
    tick();

    // Freeze for 3 cycles on top of a load-use stall
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd10, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("freeze_%0d", i), 32'(a_freeze), 32'd1);
      checkOutput($sformatf("freeze_stall_%0d", i), 32'(a_stall), 32'd0);
      checkOutput($sformatf("freeze_cnt_%0d", i), a_cnt, 32'(i));
      tick();
    end
    a_mw = 1'b0;
    @(negedge clk);
    checkOutput("unfreeze_stall", 32'(a_stall), 32'd1);
    checkOutput("unfreeze_bubble", 32'(a_bubble), 32'd1);
    checkOutput("unfreeze_freeze", 32'(a_freeze), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("freeze_done_stall", 32'(a_stall), 32'd0);
    checkOutput("freeze_done_fwd", 32'(a_fwd), 32'b0010);
    checkOutput("freeze_done_cnt", a_cnt, 32'd4);
    tick();

    // Parametrised build: two-cycle load-use stall, then forwarding from entry 2
    applyStimulusP(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulusP(1'b1, 1'b1, 5'd10, 1'b0, 5'd7, 5'd1, 5'd7, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("p_stall_%0d", i), 32'(p_stall), 32'd1);
      checkOutput($sformatf("p_bubble_%0d", i), 32'(p_bubble), 32'd1);
      tick();
    end
    @(negedge clk);
    checkOutput("p_after_stall", 32'(p_stall), 32'd0);
    checkOutput("p_after_fwd", 32'(p_fwd), 32'b011_000_011);
    checkOutput("p_cnt", p_cnt, 32'd2);
    tick();
    applyStimulusP(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulusP(1'b1, 1'b1, 5'd11, 1'b0, 5'd7, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("p_prereset_stall", 32'(p_stall), 32'd1);
    #1;
    p_br    = 1'b1;
    p_mw    = 1'b1;
    b_rst_n = 1'b0;
    #1;
    checkOutput("p_areset_stall", 32'(p_stall), 32'd0);
    checkOutput("p_areset_bubble", 32'(p_bubble), 32'd0);
    checkOutput("p_areset_flush", 32'(p_flush), 32'd0);
    checkOutput("p_areset_freeze", 32'(p_freeze), 32'd0);
    checkOutput("p_areset_fwd", 32'(p_fwd), 32'd0);
    checkOutput("p_areset_cnt", p_cnt, 32'd0);
    p_br = 1'b0;
    p_mw = 1'b0;
    #1 b_rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("p_postreset_stall", 32'(p_stall), 32'd0);
    checkOutput("p_postreset_fwd", 32'(p_fwd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
